// File: rtl/lsu_if.sv
// lsu_if: data-side bus between the load/store unit and the address mux.
//   addr      LSU -> mux   byte address (low ADDR_LEN bits)
//   rd_req    LSU -> mux   read request, held until rd_ready
//   wr_req    LSU -> mux   write request, held until wr_ready
//   be        LSU -> mux   byte enables, zero when no request is active
//   wr_data   LSU -> mux   lane-replicated store data
//   rd_ready  mux -> LSU   read completion
//   wr_ready  mux -> LSU   write completion
//   rd_data   mux -> LSU   read data, valid in the rd_ready cycle
interface lsu_if #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 14
) ();
  logic [ADDR_LEN-1:0] addr;
  logic                rd_req;
  logic                wr_req;
  logic [XLEN/8-1:0]   be;
  logic [XLEN-1:0]     wr_data;
  logic                rd_ready;
  logic                wr_ready;
  logic [XLEN-1:0]     rd_data;

  modport master (
    output addr, rd_req, wr_req, be, wr_data,
    input  rd_ready, wr_ready, rd_data
  );

  modport slave (
    input  addr, rd_req, wr_req, be, wr_data,
    output rd_ready, wr_ready, rd_data
  );
endinterface

// File: rtl/lsu.sv
// lsu: load/store unit in front of the data-side address mux.
// Accepts one operation at a time (op_valid/op_ready), rejects misaligned
// or reserved-size accesses without touching the bus, otherwise issues a
// request on the bus interface and returns a lane-extracted,
// sign/zero-extended result as a one-cycle res_valid pulse. A watchdog
// aborts requests whose ready never arrives.
//   clk, rstb              clock, asynchronous active-low reset
//   op_*                   operation from execute (valid/ready handshake)
//   res_*                  completion pulse with data, tag, writeback, exc
//   bus (lsu_if.master)    addr/rd_req/wr_req/be/wr_data, rd/wr_ready, rd_data
module lsu #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 14,
  parameter int TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic            op_is_store,
  input  logic [1:0]      op_size,
  input  logic            op_unsigned,
  input  logic [XLEN-1:0] op_addr,
  input  logic [XLEN-1:0] op_wdata,
  input  logic [4:0]      op_rd,
  output logic            res_valid,
  output logic [XLEN-1:0] res_data,
  output logic [4:0]      res_rd,
  output logic            res_we,
  output logic [1:0]      res_exc,
  lsu_if.master           bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                is_store_q, is_store_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [1:0]          alo_q, alo_d;
  logic [4:0]          rd_q, rd_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [XLEN-1:0]     wr_data_q, wr_data_d;
  logic                rd_req_q, rd_req_d;
  logic                wr_req_q, wr_req_d;
  logic                op_ready_q, op_ready_d;
  logic                res_valid_q, res_valid_d;
  logic [XLEN-1:0]     res_data_q, res_data_d;
  logic [4:0]          res_rd_q, res_rd_d;
  logic                res_we_q, res_we_d;
  logic [1:0]          res_exc_q, res_exc_d;
  logic                ready_s;

  // Address bits above the mux width are intentionally not decoded here.
  logic unused_addr_hi;
  assign unused_addr_hi = ^op_addr[XLEN-1:ADDR_LEN];

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = a[0];
      2'd2:    misaligned = (a != 2'd0);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_calc(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    be_calc = 4'b0001 << a;
      2'd1:    be_calc = 4'b0011 << a;
      2'd2:    be_calc = 4'hF;
      default: be_calc = 4'h0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lanes(input logic [1:0] size, input logic [XLEN-1:0] w);
    case (size)
      2'd0:    lanes = {4{w[7:0]}};
      2'd1:    lanes = {2{w[15:0]}};
      default: lanes = w;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extract(input logic [1:0] size, input logic uns,
                                              input logic [1:0] a, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] s;
    s = d >> {a, 3'b000};
    case (size)
      2'd0:    extract = uns ? {{(XLEN-8){1'b0}}, s[7:0]} : {{(XLEN-8){s[7]}}, s[7:0]};
      2'd1:    extract = uns ? {{(XLEN-16){1'b0}}, s[15:0]} : {{(XLEN-16){s[15]}}, s[15:0]};
      default: extract = d;
    endcase
  endfunction

  // Next-state and next-output logic; result fields are zero outside RESP.
  always_comb begin
    state_d     = state_q;
    wdog_d      = {WD_W{1'b0}};
    is_store_d  = is_store_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    alo_d       = alo_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wr_data_d   = wr_data_q;
    rd_req_d    = rd_req_q;
    wr_req_d    = wr_req_q;
    op_ready_d  = op_ready_q;
    res_valid_d = 1'b0;
    res_data_d  = {XLEN{1'b0}};
    res_rd_d    = 5'd0;
    res_we_d    = 1'b0;
    res_exc_d   = 2'd0;
    ready_s     = is_store_q ? bus.wr_ready : bus.rd_ready;

    case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready_q) begin
          is_store_d = op_is_store;
          size_d     = op_size;
          unsigned_d = op_unsigned;
          alo_d      = op_addr[1:0];
          rd_d       = op_rd;
          op_ready_d = 1'b0;
          if (misaligned(op_size, op_addr[1:0])) begin
            // Rejected before any bus activity.
            state_d     = S_RESP;
            res_valid_d = 1'b1;
            res_rd_d    = op_rd;
            res_exc_d   = 2'd1;
          end else begin
            state_d   = S_SETUP;
            addr_d    = op_addr[ADDR_LEN-1:0];
            be_d      = be_calc(op_size, op_addr[1:0]);
            wr_data_d = op_is_store ? lanes(op_size, op_wdata) : {XLEN{1'b0}};
            rd_req_d  = ~op_is_store;
            wr_req_d  = op_is_store;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        // The mux is still decoding the target; any ready now is stale.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ready_s || (wdog_q == WD_W'(TIMEOUT - 1))) begin
          state_d     = S_RESP;
          addr_d      = {ADDR_LEN{1'b0}};
          be_d        = 4'h0;
          wr_data_d   = {XLEN{1'b0}};
          rd_req_d    = 1'b0;
          wr_req_d    = 1'b0;
          res_valid_d = 1'b1;
          res_rd_d    = rd_q;
          if (ready_s) begin
            res_we_d   = ~is_store_q;
            res_data_d = is_store_q ? {XLEN{1'b0}}
                                    : extract(size_q, unsigned_q, alo_q, bus.rd_data);
          end else begin
            res_exc_d = 2'd2;
          end
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_RESP: begin
        state_d    = S_IDLE;
        op_ready_d = 1'b1;
      end
      default: begin
        state_d    = S_IDLE;
        op_ready_d = 1'b1;
        rd_req_d   = 1'b0;
        wr_req_d   = 1'b0;
        be_d       = 4'h0;
      end
    endcase
  end

  // State, latched operation fields and all registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= S_IDLE;
      wdog_q      <= {WD_W{1'b0}};
      is_store_q  <= 1'b0;
      size_q      <= 2'd0;
      unsigned_q  <= 1'b0;
      alo_q       <= 2'd0;
      rd_q        <= 5'd0;
      addr_q      <= {ADDR_LEN{1'b0}};
      be_q        <= 4'h0;
      wr_data_q   <= {XLEN{1'b0}};
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      op_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= {XLEN{1'b0}};
      res_rd_q    <= 5'd0;
      res_we_q    <= 1'b0;
      res_exc_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      is_store_q  <= is_store_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      alo_q       <= alo_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wr_data_q   <= wr_data_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
      res_we_q    <= res_we_d;
      res_exc_q   <= res_exc_d;
    end
  end

  assign op_ready    = op_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;
  assign res_we      = res_we_q;
  assign res_exc     = res_exc_q;
  assign bus.addr    = addr_q;
  assign bus.be      = be_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_req  = rd_req_q;
  assign bus.wr_req  = wr_req_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu (TIMEOUT set to 4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rstb;
  logic        op_valid, op_ready, op_is_store, op_unsigned;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata;
  logic [4:0]  op_rd;
  logic        res_valid, res_we;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic [1:0]  res_exc;
  int          n_cmp = 0;
  int          n_err = 0;

  lsu_if #(.XLEN(32), .ADDR_LEN(14)) bus ();

  lsu #(.XLEN(32), .ADDR_LEN(14), .TIMEOUT(4)) dut (
    .clk(clk), .rstb(rstb),
    .op_valid(op_valid), .op_ready(op_ready), .op_is_store(op_is_store),
    .op_size(op_size), .op_unsigned(op_unsigned), .op_addr(op_addr),
    .op_wdata(op_wdata), .op_rd(op_rd),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
    .res_we(res_we), .res_exc(res_exc), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] w, input logic [4:0] rd);
    chk("op_ready_before_offer", {31'd0, op_ready}, 32'd1);
    op_valid = 1'b1; op_is_store = st; op_size = sz; op_unsigned = uns;
    op_addr = a; op_wdata = w; op_rd = rd;
    tick();
    op_valid = 1'b0;
  endtask

  // Load with ready in the first WAIT cycle; ends one cycle after res_valid.
  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_data);
    offer(1'b0, sz, uns, a, 32'd0, rd);
    chk({tag, "_rd_req"}, {31'd0, bus.rd_req}, 32'd1);
    chk({tag, "_be"}, {28'd0, bus.be}, {28'd0, exp_be});
    chk({tag, "_addr"}, {18'd0, bus.addr}, {18'd0, a[13:0]});
    tick();
    bus.rd_ready = 1'b1; bus.rd_data = rdata;
    tick();
    bus.rd_ready = 1'b0; bus.rd_data = 32'h0;
    chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_res_data"}, res_data, exp_data);
    chk({tag, "_res_we"}, {31'd0, res_we}, 32'd1);
    chk({tag, "_res_exc"}, {30'd0, res_exc}, 32'd0);
    chk({tag, "_res_rd"}, {27'd0, res_rd}, {27'd0, rd});
    chk({tag, "_req_drop"}, {31'd0, bus.rd_req}, 32'd0);
    tick();
    chk({tag, "_pulse_end"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    rstb = 1'b0; op_valid = 1'b0; op_is_store = 1'b0; op_size = 2'd0;
    op_unsigned = 1'b0; op_addr = 32'd0; op_wdata = 32'd0; op_rd = 5'd0;
    bus.rd_ready = 1'b0; bus.wr_ready = 1'b0; bus.rd_data = 32'd0;
    tick(); tick();
    chk("rst_rd_req", {31'd0, bus.rd_req}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_be", {28'd0, bus.be}, 32'd0);
    rstb = 1'b1;
    tick();
    chk("rst_op_ready", {31'd0, op_ready}, 32'd1);

    // Word load from RAM.
    do_load("wload", 2'd2, 1'b0, 32'h0000_0104, 5'd7, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF);

    // Byte load, signed, lane 3, with a stale ready during SETUP.
    offer(1'b0, 2'd0, 1'b0, 32'h0000_0203, 5'd3, 32'd0);
    chk("bs_be", {28'd0, bus.be}, 32'h8);
    bus.rd_ready = 1'b1; bus.rd_data = 32'h5555_5555;
    tick();
    bus.rd_ready = 1'b0;
    tick();
    chk("bs_setup_ready_ignored", {31'd0, res_valid}, 32'd0);
    chk("bs_req_held", {31'd0, bus.rd_req}, 32'd1);
    bus.rd_ready = 1'b1; bus.rd_data = 32'h8011_2233;
    tick();
    bus.rd_ready = 1'b0;
    chk("bs_res_valid", {31'd0, res_valid}, 32'd1);
    chk("bs_res_data", res_data, 32'hFFFF_FF80);
    tick();

    // Same byte unsigned, then a signed halfword from lane 2.
    do_load("bu", 2'd0, 1'b1, 32'h0000_0203, 5'd4, 32'h8011_2233, 4'b1000, 32'h0000_0080);
    do_load("hs", 2'd1, 1'b0, 32'h0000_0022, 5'd5, 32'h8011_2233, 4'b1100, 32'hFFFF_8011);

    // Half store at lane 2, wr_ready late; rd_ready during WAIT must not complete it.
    offer(1'b1, 2'd1, 1'b0, 32'h0000_0042, 32'h1234_ABCD, 5'd9);
    chk("hst_wr_req", {31'd0, bus.wr_req}, 32'd1);
    chk("hst_no_rd_req", {31'd0, bus.rd_req}, 32'd0);
    chk("hst_be", {28'd0, bus.be}, 32'hC);
    chk("hst_wr_data", bus.wr_data, 32'hABCD_ABCD);
    tick();
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("hst_wr_req_held", {31'd0, bus.wr_req}, 32'd1);
    chk("hst_no_early_res", {31'd0, res_valid}, 32'd0);
    bus.wr_ready = 1'b1;
    tick();
    bus.wr_ready = 1'b0;
    chk("hst_res_valid", {31'd0, res_valid}, 32'd1);
    chk("hst_res_we", {31'd0, res_we}, 32'd0);
    chk("hst_res_exc", {30'd0, res_exc}, 32'd0);
    chk("hst_res_data", res_data, 32'd0);
    chk("hst_wr_req_drop", {31'd0, bus.wr_req}, 32'd0);
    tick();

    // Misaligned word load and reserved size.
    offer(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'd0, 5'd11);
    chk("mis_res_valid", {31'd0, res_valid}, 32'd1);
    chk("mis_res_exc", {30'd0, res_exc}, 32'd1);
    chk("mis_res_data", res_data, 32'd0);
    chk("mis_res_we", {31'd0, res_we}, 32'd0);
    chk("mis_no_req", {30'd0, bus.rd_req, bus.wr_req}, 32'd0);
    tick();
    chk("mis_pulse_end", {31'd0, res_valid}, 32'd0);
    offer(1'b1, 2'd3, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 5'd12);
    chk("rsv_res_exc", {30'd0, res_exc}, 32'd1);
    chk("rsv_no_req", {30'd0, bus.rd_req, bus.wr_req}, 32'd0);
    tick();

    // IO read that never completes: TIMEOUT=4, result 6 cycles after accept.
    offer(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'd0, 5'd13);
    for (int k = 1; k <= 5; k++) begin
      chk("to_req_held", {31'd0, bus.rd_req}, 32'd1);
      chk("to_no_res", {31'd0, res_valid}, 32'd0);
      tick();
    end
    chk("to_res_valid", {31'd0, res_valid}, 32'd1);
    chk("to_res_exc", {30'd0, res_exc}, 32'd2);
    chk("to_res_we", {31'd0, res_we}, 32'd0);
    chk("to_req_drop", {31'd0, bus.rd_req}, 32'd0);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("to_late_ready_ignored", {31'd0, res_valid}, 32'd0);

    // Reset in WAIT clears outputs at once; next op runs normally.
    offer(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0, 5'd14);
    tick();
    rstb = 1'b0;
    #1;
    chk("arst_rd_req", {31'd0, bus.rd_req}, 32'd0);
    chk("arst_be", {28'd0, bus.be}, 32'd0);
    chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
    tick();
    rstb = 1'b1;
    tick();
    chk("arst_no_res", {31'd0, res_valid}, 32'd0);
    do_load("post_rst", 2'd2, 1'b0, 32'h0000_0108, 5'd15, 32'h0123_4567, 4'hF, 32'h0123_4567);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
